// File: rtl/gpio_port_m_pkg.sv
// gpio_port_m_pkg -- constants shared between the GPIO port RTL and the CPU
// address map: the register offsets inside the port window and the base
// address at which the port window is decoded.
package gpio_port_m_pkg;

  // Base of the GPIO port window in the CPU address space. The chip select
  // is decoded outside this block from this value.
  localparam logic [15:0] GPIO_BASE_ADDR = 16'h8000;

  // Register offsets inside the port window.
  typedef enum logic [1:0] {
    OFF_OUT  = 2'd0,  // output latch, RW
    OFF_DIR  = 2'd1,  // direction, RW, 1 = output
    OFF_PIN  = 2'd2,  // synchronized pin value, RO
    OFF_FLAG = 2'd3   // rising-edge flags, RW1C
  } reg_off_e;

  // True when a CPU address falls on the given register of the port window.
  function automatic logic gpio_reg_hit(input logic [15:0] cpu_addr,
                                        input reg_off_e   off);
    return cpu_addr == (GPIO_BASE_ADDR + {14'd0, off});
  endfunction

endpackage

// File: rtl/gpio_sync_edge_m.sv
// gpio_sync_edge_m -- per-pin input synchronizer with optional rising-edge
// detect.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   pin_async    raw pin value straight from the pad
//   pin_sync     pin value after SYNC_STAGES flops
//   rise         (only with GPIO_EDGE_IRQ_EN) one-cycle pulse in the cycle
//                after pin_sync goes 0->1
//
// Macro GPIO_EDGE_IRQ_EN adds the edge-detect flop and the rise port; without
// it only the synchronizer chain exists.
module gpio_sync_edge_m
  import gpio_port_m_pkg::*;
#(
  parameter int SYNC_STAGES = 2  // 2..3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_async,
  output logic pin_sync
`ifdef GPIO_EDGE_IRQ_EN
  ,
  output logic rise
`endif
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_async};
    end
  end

  assign pin_sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_EDGE_IRQ_EN
  // Previous synchronized value. Cleared by reset so a pin that is already
  // high when reset releases is seen as a normal 0->1 transition only once
  // it has worked its way through the synchronizer.
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= pin_sync;
    end
  end

  assign rise = pin_sync & ~prev_q;
`endif

endmodule

// File: rtl/gpio_port_m.sv
// gpio_port_m -- memory-mapped GPIO port on a shared bidirectional CPU bus.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   address      register offset inside the port window (OUT/DIR/PIN/FLAG)
//   data         bidirectional CPU data bus, driven only during a read
//   CS, OE, WE   chip select, read strobe, write strobe
//   gpio         external pins, driven from OUT where DIR=1, else high-Z
//   irq          registered OR of the rising-edge flags
//
// Macro GPIO_EDGE_IRQ_EN enables the FLAG register, edge detection and irq.
// Without it FLAG reads as zero, writes to it are dropped and irq is tied low.
module gpio_port_m
  import gpio_port_m_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2  // 2..3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  CS,
  input  logic                  OE,
  input  logic                  WE,
  inout  wire  [DATA_WIDTH-1:0] gpio,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] dir_q;
  logic [DATA_WIDTH-1:0] pin_sync;
  logic [DATA_WIDTH-1:0] flag_rd;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  wr_en;
  logic                  rd_en;

  // A write strobe always wins over the read strobe, so the bus is never
  // driven while the CPU is also driving it.
  assign wr_en = CS & WE;
  assign rd_en = CS & OE & ~WE;

`ifdef GPIO_EDGE_IRQ_EN
  logic [DATA_WIDTH-1:0] rise;
`endif

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    gpio_sync_edge_m #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk      (clk),
      .reset    (reset),
      .pin_async(gpio[i]),
      .pin_sync (pin_sync[i])
`ifdef GPIO_EDGE_IRQ_EN
      ,
      .rise     (rise[i])
`endif
    );

    assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      dir_q <= '0;
    end else if (wr_en) begin
      case (reg_off_e'(address))
        OFF_OUT: out_q <= data;
        OFF_DIR: dir_q <= data;
        default: ;
      endcase
    end
  end

`ifdef GPIO_EDGE_IRQ_EN
  logic [DATA_WIDTH-1:0] flag_q;
  logic [DATA_WIDTH-1:0] flag_clr;
  logic                  irq_q;

  assign flag_clr = (wr_en && reg_off_e'(address) == OFF_FLAG) ? data : '0;

  // Clear first, then OR in new edges so a set in the same cycle survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      flag_q <= (flag_q & ~flag_clr) | rise;
      irq_q  <= |flag_q;
    end
  end

  assign flag_rd = flag_q;
  assign irq     = irq_q;
`else
  assign flag_rd = '0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (reg_off_e'(address))
      OFF_OUT:  rd_val = out_q;
      OFF_DIR:  rd_val = dir_q;
      OFF_PIN:  rd_val = pin_sync;
      OFF_FLAG: rd_val = flag_rd;
      default:  rd_val = '0;
    endcase
  end

  assign data = rd_en ? rd_val : {DATA_WIDTH{1'bz}};

endmodule

// File: doc/gpio_port_m.md
GPIO_PORT_M -- requirements
Module: gpio_port_m

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, giving the data bus width and the GPIO pin count.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops (legal values 2..3).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port address, input, 2 bits: register offset within the port window.
REQ-006 SHALL have port data, inout, DATA_WIDTH bits: the shared CPU data bus.
REQ-007 SHALL have port CS, input, 1 bit: chip select, decoded externally from address_bus.
REQ-008 SHALL have port OE, input, 1 bit: bus read strobe; the block drives data.
REQ-009 SHALL have port WE, input, 1 bit: bus write strobe; the block captures data.
REQ-010 SHALL have port gpio, inout, DATA_WIDTH bits: the external pins.
REQ-011 SHALL have port irq, output, 1 bit: edge-event request.

Function
REQ-012 SHALL implement these registers: offset 0 OUT (RW), offset 1 DIR (RW, 1 = output), offset 2 PIN (RO, synchronized pin value), offset 3 FLAG (RW1C, rising-edge flags).
REQ-013 SHALL drive gpio[i] from OUT[i] when DIR[i]=1; otherwise gpio[i] SHALL be high-Z.
REQ-014 SHALL pass every gpio bit through SYNC_STAGES flops to form PIN; PIN therefore lags a pin change by SYNC_STAGES cycles.
REQ-015 SHALL drive data with the selected register combinationally only while CS & OE & ~WE; data SHALL be high-Z at all other times.
REQ-016 SHALL perform a write on the rising edge where CS & WE: OUT or DIR takes the value on data; a write to offset 2 SHALL be ignored.
REQ-017 SHALL treat CS & WE & OE together as a write only and SHALL NOT drive data in that case.
REQ-018 SHALL set FLAG[i] in the cycle after PIN[i] goes 0->1, whatever the setting of DIR[i].
REQ-019 SHALL clear FLAG[i] on a write to offset 3 with data[i]=1.
REQ-020 SHALL let set win when a set and a clear of FLAG[i] occur in the same cycle.
REQ-021 SHALL drive irq as the registered OR of FLAG, so irq asserts one cycle after a flag sets.
REQ-022 SHALL ignore OE and WE while CS=0: no state change and no bus drive.
REQ-023 SHALL return the pin value, not OUT, when PIN is read on a bit configured as output.

Reset
REQ-024 SHALL, when reset is sampled high, load OUT=0, DIR=0 (all pins inputs), FLAG=0, irq=0 and all synchronizer flops=0.
REQ-025 SHALL let reset override any write or flag set in the same cycle.
REQ-026 SHALL NOT set any flag in the first cycle after reset deasserts, even when a pin is already high.

Configuration
REQ-027 SHALL, with macro GPIO_EDGE_IRQ_EN defined, implement FLAG, edge detection and irq as specified above.
REQ-028 SHALL, without GPIO_EDGE_IRQ_EN, read offset 3 as 0, ignore writes to offset 3, tie irq to 0, and instantiate no flag or edge-detect flops.

Structure
REQ-029 SHALL take the offset constants (OUT=0, DIR=1, PIN=2, FLAG=3) and the port base address 0x8000 from the shared package/defines used by the CPU.
REQ-030 SHALL place the per-bit synchronizer and rising-edge detect in one sub-module, gpio_sync_edge_m, instantiated DATA_WIDTH times.

Verification
REQ-031 Bench SHALL cover: write DIR=0xFF, then OUT=0xA5 -> gpio reads 0xA5 on the next cycle; read offset 0 returns 0xA5.
REQ-032 Bench SHALL cover: DIR=0x00, external gpio=0x3C -> offset 2 reads 0x3C after 2 cycles; gpio stays high-Z from the block's side.
REQ-033 Bench SHALL cover: GPIO_EDGE_IRQ_EN defined, gpio[0] 0->1 -> FLAG=0x01 at cycle 3 and irq=1 at cycle 4; write 0x01 to offset 3 -> FLAG=0 and irq=0 one cycle later.
REQ-034 Bench SHALL cover: a W1C write 0x01 to offset 3 in the same cycle as a new edge on bit 0 -> FLAG[0] stays 1.
REQ-035 Bench SHALL cover: CS=0 with WE=1 and data=0xFF at offset 1 -> DIR stays 0x00; CS=1 with OE=1 and WE=1 -> data bus high-Z and the write takes effect.
REQ-036 Bench SHALL cover: reset asserted mid-write with OUT=0x55 pending -> OUT=0, DIR=0, irq=0; without GPIO_EDGE_IRQ_EN, offset 3 reads 0x00 and irq stays 0 under any pin activity.
